// File: rtl/aes_block_assembler.sv
// Packs UART bytes MSB-first into 128-bit blocks and writes them to the AES block FIFO.
// Define AES_ASM_PAD_FLUSH_EN to zero-pad and flush a timed-out partial block instead of discarding it.
module aes_block_assembler #(
    parameter int unsigned WR_HOLD  = 1,
    parameter int unsigned COOLDOWN = 4,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_valid_i,
    input  logic         fifo_overflow_i,
    output logic [127:0] block_out_o,
    output logic         block_wr_en_o,
    output logic [4:0]   byte_count_o,
    output logic         busy_o,
    output logic         drop_err_o,
    output logic         timeout_err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned HW = 3;
    localparam int unsigned CW = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_WAIT_SPACE,
        ST_WRITE,
        ST_COOLDOWN
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   shreg_q, shreg_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [CW-1:0]  cool_q, cool_d;
    logic [127:0]   blk_q, blk_d;
    logic           wr_q, wr_d;
    logic           busy_q, busy_d;
    logic           drop_q, drop_d;
    logic           tout_q, tout_d;
    logic           accept_c;
    logic           idle_run_c;
`ifdef AES_ASM_PAD_FLUSH_EN
    logic [4:0]     pad_bytes_c;
    logic [6:0]     pad_shamt_c;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_COLLECT;
            shreg_q <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            hold_q  <= '0;
            cool_q  <= '0;
            blk_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            hold_q  <= hold_d;
            cool_q  <= cool_d;
            blk_q   <= blk_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        hold_d     = hold_q;
        cool_d     = cool_q;
        blk_d      = blk_q;
        wr_d       = wr_q;
        tout_d     = 1'b0;
`ifdef AES_ASM_PAD_FLUSH_EN
        pad_bytes_c = 5'd16 - cnt_q;
        pad_shamt_c = {pad_bytes_c[3:0], 3'b000};
`endif

        accept_c   = rx_valid_i && (cnt_q != 5'd16) && (state_q != ST_WAIT_SPACE);
        drop_d     = rx_valid_i && !accept_c;
        idle_run_c = ((state_q == ST_COLLECT) || (state_q == ST_COOLDOWN)) &&
                     (cnt_q != 5'd0) && (cnt_q != 5'd16);

        // Byte acceptance beats a coincident timeout expiry.
        if (accept_c) begin
            shreg_d = {shreg_q[119:0], rx_data_i};
            cnt_d   = cnt_q + 5'd1;
            idle_d  = '0;
        end else if (idle_run_c) begin
            if (idle_q == TW'(TIMEOUT - 1)) begin
                idle_d = '0;
                tout_d = 1'b1;
`ifdef AES_ASM_PAD_FLUSH_EN
                shreg_d = shreg_q << pad_shamt_c;
                cnt_d   = 5'd16;
`else
                shreg_d = '0;
                cnt_d   = 5'd0;
`endif
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end else if ((cnt_q == 5'd0) || (cnt_q == 5'd16)) begin
            idle_d = '0;
        end

        case (state_q)
            ST_COLLECT: begin
                if (cnt_d == 5'd16) begin
                    state_d = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (!fifo_overflow_i) begin
                    blk_d   = shreg_q;
                    wr_d    = 1'b1;
                    cnt_d   = 5'd0;
                    shreg_d = '0;
                    hold_d  = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (hold_q == HW'(WR_HOLD - 1)) begin
                    wr_d    = 1'b0;
                    cool_d  = '0;
                    state_d = ST_COOLDOWN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_COOLDOWN: begin
                if (cool_q == CW'(COOLDOWN - 1)) begin
                    state_d = (cnt_d == 5'd16) ? ST_WAIT_SPACE : ST_COLLECT;
                end else begin
                    cool_d = cool_q + CW'(1);
                end
            end
            default: state_d = ST_COLLECT;
        endcase

        busy_d = (state_d != ST_COLLECT);
    end

    assign block_out_o   = blk_q;
    assign block_wr_en_o = wr_q;
    assign byte_count_o  = cnt_q;
    assign busy_o        = busy_q;
    assign drop_err_o    = drop_q;
    assign timeout_err_o = tout_q;

endmodule

// File: tb/tb_aes_block_assembler.sv
// Scoreboard bench for aes_block_assembler: expected blocks queued as bytes are sent, checked on each strobe.
module tb_aes_block_assembler;

    localparam int unsigned WR_HOLD  = 1;
    localparam int unsigned COOLDOWN = 4;
    localparam int unsigned TIMEOUT  = 1000;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [7:0]   rx_data_i;
    logic         rx_valid_i;
    logic         fifo_overflow_i;
    logic [127:0] block_out_o;
    logic         block_wr_en_o;
    logic [4:0]   byte_count_o;
    logic         busy_o;
    logic         drop_err_o;
    logic         timeout_err_o;

    aes_block_assembler #(
        .WR_HOLD (WR_HOLD),
        .COOLDOWN(COOLDOWN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .fifo_overflow_i(fifo_overflow_i),
        .block_out_o    (block_out_o),
        .block_wr_en_o  (block_wr_en_o),
        .byte_count_o   (byte_count_o),
        .busy_o         (busy_o),
        .drop_err_o     (drop_err_o),
        .timeout_err_o  (timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    int           n_checks   = 0;
    int           n_errors   = 0;
    int           cyc        = 0;
    int           drop_cnt   = 0;
    int           strobe_cnt = 0;
    int           last_strobe = 0;
    int           strobe_gap = 0;
    int           wr_hi      = 0;
    int           n_push     = 0;
    logic [127:0] sb[$];
    logic [127:0] exp_blk    = '0;
    int           exp_n      = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Strobe monitor: pops the scoreboard on each rising write strobe and checks its width.
    always @(negedge clk_i) begin
        if (drop_err_o) drop_cnt++;
        if (block_wr_en_o) begin
            if (wr_hi == 0) begin
                strobe_cnt++;
                strobe_gap  = cyc - last_strobe;
                last_strobe = cyc;
                check_eq("sb_nonempty_at_wr", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0) check_eq("block", block_out_o, sb.pop_front());
            end
            wr_hi++;
        end else if (wr_hi != 0) begin
            check_eq("wr_width", 128'(wr_hi), 128'(WR_HOLD));
            wr_hi = 0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_raw(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_blk = {exp_blk[119:0], b};
        exp_n++;
        if (exp_n == 16) begin
            sb.push_back(exp_blk);
            n_push++;
            exp_n = 0;
        end
        send_raw(b);
    endtask

    task automatic burst(input logic [7:0] first);
        for (int i = 0; i < 16; i++) send_byte(8'(first + 8'(i)));
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (!busy_o) done = 1'b1;
            else tick();
        end
        check_eq(tag, 128'(busy_o), 128'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_blk"},  block_out_o, 128'd0);
        check_eq({tag, "_wr"},   128'(block_wr_en_o), 128'd0);
        check_eq({tag, "_cnt"},  128'(byte_count_o), 128'd0);
        check_eq({tag, "_busy"}, 128'(busy_o), 128'd0);
        check_eq({tag, "_drop"}, 128'(drop_err_o), 128'd0);
        check_eq({tag, "_tout"}, 128'(timeout_err_o), 128'd0);
    endtask

    initial begin
        int d0;
        int s0;
        int tcount;
        int tat;
        bit done;
        logic [127:0] pad_exp;

        reset_i         = 1'b1;
        rx_valid_i      = 1'b0;
        rx_data_i       = 8'h00;
        fifo_overflow_i = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset_i = 1'b0;
        tick();

        // Basic block, one byte every two cycles.
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            if (i != 15) tick();
        end
        check_eq("t1_wr_e0", 128'(block_wr_en_o), 128'd0);
        check_eq("t1_cnt16", 128'(byte_count_o), 128'd16);
        check_eq("t1_busy", 128'(busy_o), 128'd1);
        tick();
        check_eq("t1_wr_e1", 128'(block_wr_en_o), 128'd1);
        check_eq("t1_blk", block_out_o, 128'h000102030405060708090A0B0C0D0E0F);
        check_eq("t1_cnt0", 128'(byte_count_o), 128'd0);
        tick();
        check_eq("t1_wr_e2", 128'(block_wr_en_o), 128'd0);
        wait_idle("t1_idle");

        // Backpressure: FIFO full, extra byte dropped, release writes one edge later.
        fifo_overflow_i = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'hAA);
        check_eq("t2_busy", 128'(busy_o), 128'd1);
        check_eq("t2_cnt16", 128'(byte_count_o), 128'd16);
        d0 = drop_cnt;
        send_raw(8'h55);
        check_eq("t2_drop_hi", 128'(drop_err_o), 128'd1);
        tick();
        check_eq("t2_drop_lo", 128'(drop_err_o), 128'd0);
        repeat (5) tick();
        check_eq("t2_no_wr", 128'(block_wr_en_o), 128'd0);
        check_eq("t2_busy_hold", 128'(busy_o), 128'd1);
        check_eq("t2_blk_stable", block_out_o, 128'h000102030405060708090A0B0C0D0E0F);
        check_eq("t2_drop_once", 128'(drop_cnt - d0), 128'd1);
        fifo_overflow_i = 1'b0;
        tick();
        check_eq("t2_wr", 128'(block_wr_en_o), 128'd1);
        check_eq("t2_blk", block_out_o, {16{8'hAA}});
        wait_idle("t2_idle");

        // Partial block timeout.
        s0 = strobe_cnt;
        for (int i = 1; i <= 5; i++) begin
            exp_blk = {exp_blk[119:0], 8'(i)};
            send_raw(8'(i));
        end
        exp_n = 0;
`ifdef AES_ASM_PAD_FLUSH_EN
        pad_exp = 128'h0102030405 << 88;
        sb.push_back(pad_exp);
        n_push++;
`endif
        tcount = 0;
        tat    = 0;
        for (int k = 1; k <= int'(TIMEOUT) + 50; k++) begin
            tick();
            if (timeout_err_o) begin
                tcount++;
                tat = k;
            end
        end
        check_eq("t3_tout_at", 128'(tat), 128'(TIMEOUT));
        check_eq("t3_tout_once", 128'(tcount), 128'd1);
`ifdef AES_ASM_PAD_FLUSH_EN
        check_eq("t3_pad_strobe", 128'(strobe_cnt - s0), 128'd1);
`else
        check_eq("t3_cnt0", 128'(byte_count_o), 128'd0);
        check_eq("t3_no_strobe", 128'(strobe_cnt - s0), 128'd0);
`endif
        wait_idle("t3_idle");
        burst(8'h10);
        wait_idle("t3_next_idle");

        // Two bursts separated by the single WAIT_SPACE cycle.
        d0 = drop_cnt;
        s0 = strobe_cnt;
        burst(8'h20);
        tick();
        burst(8'h30);
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (strobe_cnt == s0 + 2) done = 1'b1;
            else tick();
        end
        check_eq("t4_two_strobes", 128'(strobe_cnt - s0), 128'd2);
        check_eq("t4_gap_ok", 128'(strobe_gap >= int'(WR_HOLD + COOLDOWN)), 128'd1);
        check_eq("t4_no_drop", 128'(drop_cnt - d0), 128'd0);
        wait_idle("t4_idle");

        // Reset while the write strobe is high.
        burst(8'h70);
        tick();
        check_eq("t5_wr", 128'(block_wr_en_o), 128'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_all_zero("t5_rst");
        burst(8'h80);
        wait_idle("t5_idle");
        repeat (3) tick();

        check_eq("sb_empty", 128'(sb.size()), 128'd0);
        check_eq("strobe_total", 128'(strobe_cnt), 128'(n_push));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
